// File: rtl/dot_product_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_sequencer
// Brief    : Control stage in front of the fused multiply-add unit. Accepts a
//            dot-product job (length, seed, scale), streams operand pairs into
//            the FMA, and returns the FMA's combinational sum, captured on the
//            last beat, over a valid/ready result port.
// Optional : define DOTSEQ_STALL_CNT_EN to add the stall_cnt output. It is a
//            saturating count of operand stalls seen during the current job.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_sequencer #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // job request
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [LEN_W-1:0]          job_len,
  input  logic [WIDTH-1:0]          job_seed,
  input  logic [$clog2(WIDTH)-1:0]  job_scale,
  // operand stream
  input  logic                      opnd_valid,
  output logic                      opnd_ready,
  input  logic [WIDTH-1:0]          opnd_a,
  input  logic [WIDTH-1:0]          opnd_b,
  // FMA control
  output logic [WIDTH-1:0]          fma_a,
  output logic [WIDTH-1:0]          fma_b,
  output logic [$clog2(WIDTH)-1:0]  fma_scale,
  output logic [WIDTH-1:0]          fma_seed,
  output logic                      fma_update,
  output logic                      fma_en,
  input  logic [WIDTH-1:0]          fma_acc,
  // result
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WIDTH-1:0]          res_data,
  output logic                      busy
`ifdef DOTSEQ_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int SCALE_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   remain_q;     // beats still to be consumed
  logic               first_q;      // next beat is the first one of the job
  logic [WIDTH-1:0]   seed_q;
  logic [SCALE_W-1:0] scale_q;
  logic [WIDTH-1:0]   res_data_q;
  logic               res_valid_q;
  logic               beat;

  // A beat is an accepted operand pair; the sequencer is only ready in RUN.
  assign beat       = (state_q == S_RUN) && opnd_valid;

  assign job_ready  = (state_q == S_IDLE);
  assign opnd_ready = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE);

  // Operands pass straight through; seed and scale come from the job latch.
  assign fma_a      = opnd_a;
  assign fma_b      = opnd_b;
  assign fma_scale  = scale_q;
  assign fma_seed   = seed_q;
  assign fma_en     = beat;
  // The first beat restarts from the seed so a stale FMA accumulator from an
  // earlier or aborted job can never leak into this result.
  assign fma_update = beat && first_q;

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;

  // Job sequencing FSM: latch job, count beats, capture and hand off result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remain_q    <= '0;
      first_q     <= 1'b0;
      seed_q      <= '0;
      scale_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (job_valid) begin
            seed_q  <= job_seed;
            scale_q <= job_scale;
            if (job_len != '0) begin
              remain_q <= job_len;
              first_q  <= 1'b1;
              state_q  <= S_RUN;
            end else begin
              // Empty job: the seed is the answer, the FMA stays idle.
              res_data_q  <= job_seed;
              res_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (beat) begin
            first_q  <= 1'b0;
            remain_q <= remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
              // Capture the FMA's combinational sum for the final beat.
              res_data_q  <= fma_acc;
              res_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DOTSEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Next stall count: clear on job accept, saturating increment on RUN stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && job_valid) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_RUN) && !opnd_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register; value is held through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dot_product_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_sequencer
// Brief    : Self-checking bench for dot_product_sequencer with a behavioural
//            FMA attached and a plain-arithmetic dot-product reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_sequencer;

  localparam int WIDTH   = 32;
  localparam int LEN_W   = 8;
  localparam int SCALE_W = $clog2(WIDTH);

  logic               clk;
  logic               rst_n;
  logic               job_valid;
  logic               job_ready;
  logic [LEN_W-1:0]   job_len;
  logic [WIDTH-1:0]   job_seed;
  logic [SCALE_W-1:0] job_scale;
  logic               opnd_valid;
  logic               opnd_ready;
  logic [WIDTH-1:0]   opnd_a;
  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH-1:0]   fma_a;
  logic [WIDTH-1:0]   fma_b;
  logic [SCALE_W-1:0] fma_scale;
  logic [WIDTH-1:0]   fma_seed;
  logic               fma_update;
  logic               fma_en;
  logic [WIDTH-1:0]   fma_acc;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic               busy;
`ifdef DOTSEQ_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Per-job stimulus tables
  logic [WIDTH-1:0] pa  [0:255];
  logic [WIDTH-1:0] pb  [0:255];
  int               gap [0:255];

  dot_product_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_len    (job_len),
    .job_seed   (job_seed),
    .job_scale  (job_scale),
    .opnd_valid (opnd_valid),
    .opnd_ready (opnd_ready),
    .opnd_a     (opnd_a),
    .opnd_b     (opnd_b),
    .fma_a      (fma_a),
    .fma_b      (fma_b),
    .fma_scale  (fma_scale),
    .fma_seed   (fma_seed),
    .fma_update (fma_update),
    .fma_en     (fma_en),
    .fma_acc    (fma_acc),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
`ifdef DOTSEQ_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FMA: combinational sum of (seed or stored acc) + scaled product.
  logic [WIDTH-1:0] fma_acc_reg = 32'hDEAD_BEEF;
  longint           fma_prod;
  always_comb begin
    fma_prod = (longint'($signed(fma_a)) * longint'($signed(fma_b))) >>> fma_scale;
    fma_acc  = (fma_update ? fma_seed : fma_acc_reg) + fma_prod[WIDTH-1:0];
  end
  always @(posedge clk) if (fma_en) fma_acc_reg <= fma_acc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Dot product from first principles: seed + sum of arithmetically shifted products, wrapped.
  function automatic logic [WIDTH-1:0] ref_dot(input int len, input logic [WIDTH-1:0] seed, input int scale);
    longint acc;
    acc = longint'($signed(seed));
    for (int i = 0; i < len; i++)
      acc += (longint'($signed(pa[i])) * longint'($signed(pb[i]))) >>> scale;
    return acc[WIDTH-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one complete job from IDLE through result hand-off.
  task automatic run_job(input string nm, input int len, input logic [WIDTH-1:0] seed,
                         input int scale, input int hold);
    logic [WIDTH-1:0] exp;
    int stalls;
    exp    = ref_dot(len, seed, scale);
    stalls = 0;
    chk({nm, "_job_ready"}, job_ready, 1);
    job_valid = 1'b1;
    job_len   = LEN_W'(len);
    job_seed  = seed;
    job_scale = SCALE_W'(scale);
    step();
    job_valid = 1'b0;
    job_len   = LEN_W'($urandom);
    job_seed  = $urandom;
    job_scale = SCALE_W'($urandom);
    chk({nm, "_busy"}, busy, 1);
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        opnd_valid = 1'b0;
        opnd_a     = $urandom;
        opnd_b     = $urandom;
        #1;
        chk({nm, "_gap_en_upd"}, {fma_en, fma_update}, 0);
        stalls++;
        step();
      end
      opnd_valid = 1'b1;
      opnd_a     = pa[i];
      opnd_b     = pb[i];
      #1;
      chk({nm, "_beat_en_upd"}, {fma_en, fma_update}, {1'b1, (i == 0)});
      chk({nm, "_beat_res_valid"}, res_valid, 0);
      step();
    end
    opnd_valid = 1'b0;
    chk({nm, "_res_valid"}, res_valid, 1);
    chk({nm, "_res_data"}, res_data, exp);
`ifdef DOTSEQ_STALL_CNT_EN
    chk({nm, "_stall_cnt"}, stall_cnt, stalls);
`endif
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) step();
    if (hold > 0) begin
      chk({nm, "_hold_data"}, res_data, exp);
      chk({nm, "_hold_flags"}, {res_valid, job_ready, fma_en}, 3'b100);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({nm, "_after_take"}, {res_valid, job_ready, busy}, 3'b010);
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < 256; i++) gap[i] = 0;
  endtask

  initial begin
    rst_n      = 1'b0;
    job_valid  = 1'b0;
    job_len    = '0;
    job_seed   = '0;
    job_scale  = '0;
    opnd_valid = 1'b0;
    opnd_a     = '0;
    opnd_b     = '0;
    res_ready  = 1'b0;
    clear_gaps();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_state", {job_ready, busy, res_valid, opnd_ready, fma_en, fma_update}, 6'b100000);
    chk("reset_res_data", res_data, 0);

    // len=3 seed=10 back-to-back -> 10+2+12+30 = 54
    pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6;
    run_job("t1", 3, 32'd10, 0, 0);
    chk("t1_value", ref_dot(3, 32'd10, 0), 32'd54);

    // len=2 scale=1 with two idle cycles between beats -> 8 + (-8) = 0
    pa[0] = 4; pb[0] = 4; pa[1] = -32'sd3; pb[1] = 5; gap[1] = 2;
    run_job("t2", 2, 32'd0, 1, 0);
    clear_gaps();

    // Empty job returns the seed one cycle after accept
    run_job("t3", 0, -32'sd7, 0, 0);

    // Held result, then a second job must not inherit the old accumulator
    pa[0] = 2; pb[0] = 3;
    run_job("t4a", 1, 32'd0, 0, 5);
    pa[0] = 1; pb[0] = 1;
    run_job("t4b", 1, 32'd100, 0, 0);

    // Asynchronous reset after beat 1 of a len=4 job
    job_valid = 1'b1; job_len = 8'd4; job_seed = 32'd3; job_scale = '0;
    step();
    job_valid = 1'b0;
    opnd_valid = 1'b1; opnd_a = 32'd9; opnd_b = 32'd9;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {res_valid, busy, job_ready, fma_en}, 4'b0010);
    opnd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    pa[0] = 5; pb[0] = 5;
    run_job("t5", 1, 32'd0, 0, 0);

    // Two's-complement wrap, no saturation
    pa[0] = 1; pb[0] = 1;
    run_job("t6_wrap", 1, 32'h7FFF_FFFF, 0, 0);

    // Maximum length job
    for (int i = 0; i < 255; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
    run_job("t7_maxlen", 255, $urandom, $urandom_range(0, 31), 0);

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      int len;
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        pa[i]  = $urandom;
        pb[i]  = $urandom;
        gap[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      end
      run_job("rnd", len, $urandom, $urandom_range(0, 31), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) step();
    end
    clear_gaps();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
